// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the Wishbone round-robin arbiter and crossbar.
package wb_arb_pkg;

  localparam int WB_SEL_WIDTH = 4;

  typedef enum logic {
    IDLE,
    OWNED
  } arb_state_t;

  // Next index in the rotation, wrapping from nm-1 back to 0.
  function automatic int rr_next(input int idx, input int nm);
    return (idx >= nm - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: the first requester after i_last (wrapping) wins.
module rr_pick
  import wb_arb_pkg::*;
#(
  parameter int NM = 2,
  parameter int LW = (NM > 1) ? $clog2(NM) : 1
) (
  input  logic [NM-1:0] i_req,
  input  logic [LW-1:0] i_last,
  output logic [NM-1:0] o_win,
  output logic          o_any
);

  always_comb begin
    int   idx;
    logic found;
    o_win = '0;
    found = 1'b0;
    idx   = int'(i_last);
    for (int k = 0; k < NM; k++) begin
      idx = rr_next(idx, NM);
      for (int j = 0; j < NM; j++) begin
        if (!found && (j == idx) && i_req[j]) begin
          o_win[j] = 1'b1;
          found    = 1'b1;
        end
      end
    end
    o_any = found;
  end

endmodule

// File: rtl/wbc_rr_arbiter.sv
// Round-robin arbiter sharing one classic-Wishbone slave among NM masters,
// with grant held for a whole cyc tenure and a watchdog forcing err on stalls.
module wbc_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NM      = 2,
  parameter int AW      = 28,
  parameter int DW      = 32,
  parameter int SW      = DW / 8,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NM-1:0]    i_mcyc,
  input  logic [NM-1:0]    i_mstb,
  input  logic [NM-1:0]    i_mwe,
  input  logic [NM*AW-1:0] i_maddr,
  input  logic [NM*DW-1:0] i_mdata,
  input  logic [NM*SW-1:0] i_msel,
  output logic [NM-1:0]    o_mack,
  output logic [NM-1:0]    o_merr,
  output logic [DW-1:0]    o_mdata,
  output logic             o_scyc,
  output logic             o_sstb,
  output logic             o_swe,
  output logic [AW-1:0]    o_saddr,
  output logic [DW-1:0]    o_sdata,
  output logic [SW-1:0]    o_ssel,
  input  logic             i_sack,
  input  logic             i_serr,
  input  logic [DW-1:0]    i_sdata,
  output logic [NM-1:0]    o_grant
);

  localparam int LW = (NM > 1) ? $clog2(NM) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  arb_state_t    r_state, w_state_nxt;
  logic [NM-1:0] r_grant, w_grant_nxt;
  logic [LW-1:0] r_last, w_last_nxt;
  logic [CW-1:0] r_wdog, w_wdog_nxt;

  logic [NM-1:0] w_win;
  logic          w_any;
  logic [LW-1:0] w_gidx;
  logic          w_cyc, w_stb, w_we, w_timeout;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;
  logic [SW-1:0] w_sel;

  rr_pick #(
    .NM(NM),
    .LW(LW)
  ) u_pick (
    .i_req (i_mcyc),
    .i_last(r_last),
    .o_win (w_win),
    .o_any (w_any)
  );

  // AND-OR mux on the registered one-hot grant; an all-zero grant yields all-zero outputs.
  always_comb begin
    w_cyc  = |(i_mcyc & r_grant);
    w_stb  = |(i_mstb & r_grant);
    w_we   = |(i_mwe & r_grant);
    w_addr = '0;
    w_data = '0;
    w_sel  = '0;
    w_gidx = '0;
    for (int j = 0; j < NM; j++) begin
      w_addr = w_addr | (i_maddr[j*AW +: AW] & {AW{r_grant[j]}});
      w_data = w_data | (i_mdata[j*DW +: DW] & {DW{r_grant[j]}});
      w_sel  = w_sel | (i_msel[j*SW +: SW] & {SW{r_grant[j]}});
      if (r_grant[j]) w_gidx = LW'(j);
    end
  end

  assign w_timeout = (TIMEOUT != 0) && (r_state == OWNED) && w_stb && !i_sack && !i_serr
                     && (r_wdog == CW'(TIMEOUT));

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    w_wdog_nxt  = '0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt = OWNED;
          w_grant_nxt = w_win;
        end
      end
      OWNED: begin
        if (!w_cyc) begin
          w_state_nxt = IDLE;
          w_grant_nxt = '0;
          w_last_nxt  = w_gidx;
        end else if (w_stb && !i_sack && !i_serr && !w_timeout) begin
          w_wdog_nxt = r_wdog + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // last starts at NM-1 so master 0 is first in line after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_last  <= LW'(NM - 1);
      r_wdog  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
      r_wdog  <= w_wdog_nxt;
    end
  end

  assign o_grant = r_grant;
  assign o_scyc  = w_cyc & ~w_timeout;
  assign o_sstb  = w_stb & ~w_timeout;
  assign o_swe   = w_we;
  assign o_saddr = w_addr;
  assign o_sdata = w_data;
  assign o_ssel  = w_sel;
  assign o_mack  = r_grant & {NM{i_sack}};
  assign o_merr  = r_grant & {NM{i_serr | w_timeout}};
  assign o_mdata = i_sdata;

endmodule

// File: tb/tb_wbc_rr_arbiter.sv
// Self-checking bench for wbc_rr_arbiter: directed scenarios plus a random run,
// all compared against a tenure-level reference model of the arbitration rules.
module tb_wbc_rr_arbiter;

  localparam int NM = 2;
  localparam int AW = 28;
  localparam int DW = 32;
  localparam int SW = wb_arb_pkg::WB_SEL_WIDTH;
  localparam int TO = 4;
  localparam int VW = 3*NM + 3 + AW + DW + SW + DW;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [NM-1:0]    mcyc, mstb, mwe;
  logic [NM*AW-1:0] maddr;
  logic [NM*DW-1:0] mdata;
  logic [NM*SW-1:0] msel;
  logic             sack, serr;
  logic [DW-1:0]    sdata;
  logic [NM-1:0]    o_mack, o_merr, o_grant;
  logic [DW-1:0]    o_mdata, o_sdata;
  logic             o_scyc, o_sstb, o_swe;
  logic [AW-1:0]    o_saddr;
  logic [SW-1:0]    o_ssel;
  logic [VW-1:0]    actAll;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the bus (-1 = nobody), who owned it last, stall count.
  int mOwner = -1;
  int mLast  = NM - 1;
  int mCount = 0;

  always #5 clk = ~clk;

  wbc_rr_arbiter #(
    .NM(NM), .AW(AW), .DW(DW), .SW(SW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .i_mcyc(mcyc), .i_mstb(mstb), .i_mwe(mwe),
    .i_maddr(maddr), .i_mdata(mdata), .i_msel(msel),
    .o_mack(o_mack), .o_merr(o_merr), .o_mdata(o_mdata),
    .o_scyc(o_scyc), .o_sstb(o_sstb), .o_swe(o_swe),
    .o_saddr(o_saddr), .o_sdata(o_sdata), .o_ssel(o_ssel),
    .i_sack(sack), .i_serr(serr), .i_sdata(sdata),
    .o_grant(o_grant)
  );

  assign actAll = {o_grant, o_mack, o_merr, o_scyc, o_sstb, o_swe, o_saddr, o_sdata, o_ssel, o_mdata};

  // A stall times out once TO unanswered strobe cycles have already gone by.
  function automatic logic modelTimeout();
    if (TO == 0 || mOwner < 0) return 1'b0;
    return mstb[mOwner] && !sack && !serr && (mCount == TO);
  endfunction

  // First requesting master scanning forward from the one after the last owner.
  function automatic int rrWinner();
    for (int i = 1; i <= NM; i++)
      if (mcyc[(mLast + i) % NM]) return (mLast + i) % NM;
    return -1;
  endfunction

  // Expected output bundle for the current model state and bench inputs.
  function automatic logic [VW-1:0] expAll();
    logic [NM-1:0] g, ak, er;
    logic          cy, sb, we, to;
    logic [AW-1:0] ad;
    logic [DW-1:0] dt;
    logic [SW-1:0] sl;
    g = '0; ak = '0; er = '0; cy = 0; sb = 0; we = 0; ad = '0; dt = '0; sl = '0;
    to = modelTimeout();
    if (mOwner >= 0) begin
      g[mOwner]  = 1'b1;
      cy         = mcyc[mOwner] && !to;
      sb         = mstb[mOwner] && !to;
      we         = mwe[mOwner];
      ad         = maddr[mOwner*AW +: AW];
      dt         = mdata[mOwner*DW +: DW];
      sl         = msel[mOwner*SW +: SW];
      ak[mOwner] = sack;
      er[mOwner] = serr || to;
    end
    return {g, ak, er, cy, sb, we, ad, dt, sl, sdata};
  endfunction

  // Model advances on each clock edge from the inputs the bench is holding.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mOwner <= -1;
      mLast  <= NM - 1;
      mCount <= 0;
    end else if (mOwner < 0) begin
      mOwner <= rrWinner();
      mCount <= 0;
    end else if (!mcyc[mOwner]) begin
      mLast  <= mOwner;
      mOwner <= -1;
      mCount <= 0;
    end else if (mstb[mOwner] && !sack && !serr && !modelTimeout()) begin
      mCount <= mCount + 1;
    end else begin
      mCount <= 0;
    end
  end

  task automatic applyStimulus(input int m, input logic cyc, input logic stb, input logic we,
                               input logic [AW-1:0] addr, input logic [DW-1:0] data);
    mcyc[m]            = cyc;
    mstb[m]            = stb;
    mwe[m]             = we;
    maddr[m*AW +: AW]  = addr;
    mdata[m*DW +: DW]  = data;
    msel[m*SW +: SW]   = SW'($urandom);
  endtask

  task automatic clearStimulus();
    mcyc = '0; mstb = '0; mwe = '0; maddr = '0; mdata = '0; msel = '0;
    sack = 1'b0; serr = 1'b0; sdata = '0;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    clearStimulus();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    clearStimulus();
    #1;
    checks++;
    if (o_grant !== 2'b00) begin errors++; $display("[TB] FAIL reset_grant: got %b expected 00", o_grant); end
    checks++;
    if ({o_scyc, o_sstb, o_mack, o_merr} !== 6'b0) begin
      errors++; $display("[TB] FAIL reset_ctrl: got %b expected 000000", {o_scyc, o_sstb, o_mack, o_merr});
    end
    checks++;
    if (actAll !== expAll()) begin errors++; $display("[TB] FAIL reset_model: got %h expected %h", actAll, expAll()); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    logic [1:0] gExp [5] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00};
    logic [1:0] aExp [5] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      sdata = $urandom;
      case (c)
        0: applyStimulus(0, 1'b1, 1'b1, 1'b0, 28'h0000100, '0);
        2: begin sack = 1'b1; sdata = 32'hDEADBEEF; end
        3: begin sack = 1'b0; applyStimulus(0, 1'b0, 1'b0, 1'b0, '0, '0); end
        default: ;
      endcase
      #1;
      checks++;
      if (actAll !== expAll()) begin errors++; $display("[TB] FAIL read_model c%0d: got %h expected %h", c, actAll, expAll()); end
      checks++;
      if (o_grant !== gExp[c]) begin errors++; $display("[TB] FAIL read_grant c%0d: got %b expected %b", c, o_grant, gExp[c]); end
      checks++;
      if (o_mack !== aExp[c]) begin errors++; $display("[TB] FAIL read_ack c%0d: got %b expected %b", c, o_mack, aExp[c]); end
      if (c == 1) begin
        checks++;
        if (o_saddr !== 28'h0000100) begin errors++; $display("[TB] FAIL read_addr: got %h expected 0000100", o_saddr); end
      end
      if (c == 2) begin
        checks++;
        if (o_mdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL read_data: got %h expected deadbeef", o_mdata); end
      end
    end
    clearStimulus();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_alternate();
    logic [1:0] g;
    int w;
    doReset();
    for (int k = 0; k < 4; k++) begin
      w = k % 2;
      g = (w == 0) ? 2'b01 : 2'b10;
      if (k == 0) begin
        @(negedge clk);
        applyStimulus(0, 1'b1, 1'b1, 1'b1, 28'($urandom), $urandom);
        applyStimulus(1, 1'b1, 1'b1, 1'b1, 28'($urandom), $urandom);
        #1;
        checks++;
        if (o_grant !== 2'b00) begin errors++; $display("[TB] FAIL alt_first_idle: got %b expected 00", o_grant); end
      end
      @(negedge clk);
      sack = 1'b1;
      #1;
      checks++;
      if (actAll !== expAll()) begin errors++; $display("[TB] FAIL alt_model k%0d: got %h expected %h", k, actAll, expAll()); end
      checks++;
      if (o_grant !== g) begin errors++; $display("[TB] FAIL alt_grant k%0d: got %b expected %b", k, o_grant, g); end
      checks++;
      if (o_mack !== g || o_swe !== 1'b1) begin
        errors++; $display("[TB] FAIL alt_ack k%0d: got %b/%b expected %b/1", k, o_mack, o_swe, g);
      end
      @(negedge clk);
      sack = 1'b0;
      applyStimulus(w, 1'b0, 1'b0, 1'b0, '0, '0);
      #1;
      checks++;
      if (o_scyc !== 1'b0) begin errors++; $display("[TB] FAIL alt_release k%0d: got %b expected 0", k, o_scyc); end
      @(negedge clk);
      applyStimulus(w, 1'b1, 1'b1, 1'b1, 28'($urandom), $urandom);
      #1;
      checks++;
      if (o_grant !== 2'b00 || o_scyc !== 1'b0) begin
        errors++; $display("[TB] FAIL alt_dead k%0d: got %b/%b expected 00/0", k, o_grant, o_scyc);
      end
    end
    clearStimulus();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_hold();
    logic [1:0] gExp [10] = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01};
    logic [1:0] aExp [10] = '{2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00};
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      sdata = $urandom;
      case (c)
        0: applyStimulus(1, 1'b1, 1'b1, 1'b0, 28'($urandom), '0);
        1: begin applyStimulus(0, 1'b1, 1'b1, 1'b1, 28'($urandom), $urandom); sack = 1'b1; end
        2, 4: begin mstb[1] = 1'b0; sack = 1'b0; end
        3, 5: begin applyStimulus(1, 1'b1, 1'b1, 1'b0, 28'($urandom), '0); sack = 1'b1; end
        6: begin applyStimulus(1, 1'b0, 1'b0, 1'b0, '0, '0); sack = 1'b0; end
        9: applyStimulus(0, 1'b0, 1'b0, 1'b0, '0, '0);
        default: ;
      endcase
      #1;
      checks++;
      if (actAll !== expAll()) begin errors++; $display("[TB] FAIL hold_model c%0d: got %h expected %h", c, actAll, expAll()); end
      checks++;
      if (o_grant !== gExp[c] || o_mack !== aExp[c]) begin
        errors++; $display("[TB] FAIL hold_grant c%0d: got %b/%b expected %b/%b", c, o_grant, o_mack, gExp[c], aExp[c]);
      end
      if (aExp[c] != 2'b00) begin
        checks++;
        if (o_mdata !== sdata) begin errors++; $display("[TB] FAIL hold_rdata c%0d: got %h expected %h", c, o_mdata, sdata); end
      end
    end
    clearStimulus();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timeout();
    logic [1:0] gExp [14] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01,
                              2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
    logic       sExp [14] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1,
                              1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [1:0] eExp, aExp;
    logic [AW-1:0] a = 28'($urandom);
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      case (c)
        0: applyStimulus(0, 1'b1, 1'b1, 1'b0, a, '0);
        10: sack = 1'b1;
        11: begin sack = 1'b0; mstb[0] = 1'b0; end
        12: applyStimulus(0, 1'b0, 1'b0, 1'b0, '0, '0);
        default: ;
      endcase
      eExp = (c == 5) ? 2'b01 : 2'b00;
      aExp = (c == 10) ? 2'b01 : 2'b00;
      #1;
      checks++;
      if (actAll !== expAll()) begin errors++; $display("[TB] FAIL wdog_model c%0d: got %h expected %h", c, actAll, expAll()); end
      checks++;
      if (o_grant !== gExp[c] || o_sstb !== sExp[c]) begin
        errors++; $display("[TB] FAIL wdog_stb c%0d: got %b/%b expected %b/%b", c, o_grant, o_sstb, gExp[c], sExp[c]);
      end
      checks++;
      if (o_merr !== eExp || o_mack !== aExp) begin
        errors++; $display("[TB] FAIL wdog_err c%0d: got %b/%b expected %b/%b", c, o_merr, o_mack, eExp, aExp);
      end
    end
    clearStimulus();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_serr();
    logic [1:0] gExp [8] = '{2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10};
    logic [1:0] eExp [8] = '{2'b00, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00};
    logic [1:0] aExp [8] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00};
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      case (c)
        0: begin
          applyStimulus(0, 1'b1, 1'b1, 1'b1, 28'($urandom), $urandom);
          applyStimulus(1, 1'b1, 1'b1, 1'b1, 28'($urandom), $urandom);
        end
        1: serr = 1'b1;
        2: begin serr = 1'b0; applyStimulus(1, 1'b0, 1'b0, 1'b0, '0, '0); end
        3: applyStimulus(1, 1'b1, 1'b1, 1'b0, 28'($urandom), '0);
        4: begin sack = 1'b1; serr = 1'b1; end
        5: begin sack = 1'b0; serr = 1'b0; applyStimulus(0, 1'b0, 1'b0, 1'b0, '0, '0); end
        default: ;
      endcase
      #1;
      checks++;
      if (actAll !== expAll()) begin errors++; $display("[TB] FAIL serr_model c%0d: got %h expected %h", c, actAll, expAll()); end
      checks++;
      if (o_grant !== gExp[c] || o_merr !== eExp[c] || o_mack !== aExp[c]) begin
        errors++;
        $display("[TB] FAIL serr_route c%0d: got %b/%b/%b expected %b/%b/%b",
                 c, o_grant, o_merr, o_mack, gExp[c], eExp[c], aExp[c]);
      end
    end
    clearStimulus();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [1:0] gExp [5] = '{2'b00, 2'b10, 2'b00, 2'b00, 2'b01};
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      case (c)
        0: applyStimulus(1, 1'b1, 1'b1, 1'b1, 28'($urandom | 1), $urandom | 1);
        2: begin rst = 1'b1; sack = 1'b1; applyStimulus(0, 1'b1, 1'b1, 1'b0, 28'($urandom), '0); end
        3: begin rst = 1'b0; sack = 1'b0; end
        default: ;
      endcase
      #1;
      checks++;
      if (actAll !== expAll()) begin errors++; $display("[TB] FAIL rstmid_model c%0d: got %h expected %h", c, actAll, expAll()); end
      checks++;
      if (o_grant !== gExp[c]) begin errors++; $display("[TB] FAIL rstmid_grant c%0d: got %b expected %b", c, o_grant, gExp[c]); end
      if (c == 2) begin
        checks++;
        if ({o_mack, o_merr, o_scyc, o_sstb, o_swe, o_saddr, o_sdata, o_ssel} !== '0) begin
          errors++;
          $display("[TB] FAIL rstmid_zero: got %b/%b/%b%b%b/%h/%h/%h expected all zero",
                   o_mack, o_merr, o_scyc, o_sstb, o_swe, o_saddr, o_sdata, o_ssel);
        end
      end
    end
    clearStimulus();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    logic cyc;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      for (int m = 0; m < NM; m++) begin
        cyc = mcyc[m] ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 2) == 0);
        applyStimulus(m, cyc, cyc & 1'($urandom), 1'($urandom), 28'($urandom), $urandom);
      end
      sack  = ($urandom_range(0, 3) == 0);
      serr  = ($urandom_range(0, 15) == 0);
      sdata = $urandom;
      #1;
      checks++;
      if (actAll !== expAll()) begin errors++; $display("[TB] FAIL rand_model c%0d: got %h expected %h", c, actAll, expAll()); end
    end
    clearStimulus();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    clearStimulus();
    $display("[TB] starting wbc_rr_arbiter bench");
    test_reset();
    test_single_read();
    test_alternate();
    test_hold();
    test_timeout();
    test_serr();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wbc_rr_arbiter.md
# wbc_rr_arbiter

Round-robin arbiter that lets NM classic-Wishbone masters share a single slave port. It is used in front of shared resources in the base system, such as the QSPI flash window or a SPRAM bank, when a second requester (DMA, debug bridge) must reach the same slave as the CPU data bus. Grants are held for a master's whole `cyc` tenure. A bus watchdog terminates stalled cycles with `err`.

## Interface
- `NM`, default 2: number of masters (2..8).
- `AW`, default 28: word-address width.
- `DW`, default 32: data width.
- `SW`, default `DW/8`: byte-select width.
- `TIMEOUT`, default 255: maximum cycles with `stb` high and no `ack`/`err` before the arbiter forces `err`. A value of 0 disables the watchdog.

Ports (master i occupies slice i of each vector; index 0 is the LSB slice):
- `clk`  in  1  clock
- `rst`  in  1  reset; asynchronous, active-high
- `i_mcyc`, `i_mstb`, `i_mwe`  in  NM each  master cycle, strobe and write-enable
- `i_maddr`  in  NM*AW  master addresses
- `i_mdata`  in  NM*DW  master write data
- `i_msel`  in  NM*SW  master byte selects
- `o_mack`, `o_merr`  out  NM each  per-master acknowledge and error
- `o_mdata`  out  DW  read data, broadcast to all masters
- `o_scyc`, `o_sstb`, `o_swe`  out  1 each  slave cycle, strobe and write-enable
- `o_saddr`  out  AW  slave address
- `o_sdata`  out  DW  slave write data
- `o_ssel`  out  SW  slave byte selects
- `i_sack`, `i_serr`  in  1 each  slave acknowledge and error
- `i_sdata`  in  DW  slave read data
- `o_grant`  out  NM  one-hot registered grant; all zeros when idle

## Operation
- FSM states are `IDLE` and `OWNED`.
- **IDLE**
  - All slave outputs are 0 and `o_mack`/`o_merr` are 0.
  - If any `i_mcyc` is high, pick the winner by round-robin starting at index `last+1` (mod NM).
  - Register `o_grant` to the winner and move to `OWNED`.
- **OWNED**
  - The granted master's `cyc`, `stb`, `we`, `addr`, `data` and `sel` drive the slave port combinationally.
  - `i_sack` and `i_serr` route only to the granted bit of `o_mack`/`o_merr`.
  - `o_mdata` equals `i_sdata` at all times.
  - Ungranted masters see `ack` and `err` held at 0.
- **Release**
  - When the granted `i_mcyc` falls, the FSM returns to `IDLE`, `last` is set to the granted index, and `o_grant` clears.
  - `o_scyc` follows the master combinationally, so it drops in the same cycle the master releases.
- **Ownership**
  - A master keeps the grant across any number of back-to-back `stb` transactions while `cyc` stays high. There is no preemption.
- **Watchdog**
  - A counter (width `$clog2(TIMEOUT+1)`) increments in `OWNED` on every cycle with `o_sstb` high and both `i_sack` and `i_serr` low.
  - The counter clears on `ack`, on `err`, on `stb` low, and in `IDLE`.
  - When the count reaches `TIMEOUT`, that cycle asserts `err` to the granted master and forces `o_scyc`/`o_sstb` to 0. The counter then clears.
  - The grant is kept until the master drops `cyc`.
- **Simultaneous events**
  - If `i_sack` and `i_serr` are high together, both are forwarded.
  - If a timeout coincides with `i_sack`, the `ack` wins and the counter clears.
- **Reset**
  - State `IDLE`, `o_grant`=0, counter=0, `last`=NM-1, so master 0 has first priority.
  - Reset asserted mid-cycle drops every output to 0 immediately (asynchronously).

## Timing
- Arbitration latency is one cycle: a request seen in `IDLE` at edge n reaches the slave from cycle n+1.
- In `OWNED`, request and response paths are combinational pass-through with zero added latency.
- There is one dead cycle between tenures: after a `cyc` drop, the next grant is registered one edge later.
- With TIMEOUT=T, `err` is asserted in the (T+1)-th consecutive unacknowledged `stb` cycle.
- A request whose `cyc` falls during `IDLE` before being granted is simply not granted; no state changes.

## Structure
- Shared package `wb_arb_pkg`:
  - `arb_state_t` enum (`IDLE`, `OWNED`).
  - A `rr_next` index helper.
  - The `WB_SEL_WIDTH`=4 constant.
- Sub-module `rr_pick`: combinational rotating priority encoder (`req[NM]`, `last` -> one-hot `win`, `any`). It is reused by the crossbar.
- Datapath muxes use the registered one-hot `o_grant` as the select (AND-OR mux).

## Test plan
1. Master 0 alone reads addr 0x0000100; slave acks with 0xDEADBEEF on its 2nd `stb` cycle -> `o_grant`=01, `o_mack`=01 for 1 cycle, `o_mdata`=0xDEADBEEF, `o_mack[1]`=0 throughout.
2. Both masters raise `cyc` in the same cycle and each does 1 write per tenure, repeated 4 times -> grants alternate 0,1,0,1 with one `IDLE` cycle between tenures.
3. Master 1 holds `cyc` for 3 reads while master 0 requests -> master 0 is granted only after master 1 drops `cyc`; master 0 never sees `ack`.
4. TIMEOUT=4 and the slave never acks -> `o_merr` pulses on the 5th `stb` cycle, with `o_sstb`=0 that cycle; the grant is held until the master drops `cyc`.
5. Slave returns `i_serr` on a write -> the granted master gets `err` and the other master gets nothing; the round-robin pointer still advances.
6. Assert `rst` mid-transaction for 1 cycle -> all outputs are 0 within the same cycle; after release, master 0 has first priority.
